// File: rtl/fmdll_lock_ctrl.sv
// fmdll_lock_ctrl: SAR coarse search plus linear tracking lock controller for the FM-DLL.
// Optional build macro FMDLL_PD_FILTER_EN adds a 3-sample majority filter on pd_lag.
module fmdll_lock_ctrl #(
   parameter int CODE_W    = 6,
   parameter int SEL_W     = 2,
   parameter int NUM_BANDS = 4,
   parameter int M_W       = 2,
   parameter int N_W       = 4,
   parameter int SETTLE    = 4,
   parameter int LOCK_CNT  = 8,
   parameter int LOSS_CNT  = 4
) (
   input  logic              clk_ext,
   input  logic              rst_n,
   input  logic [M_W-1:0]    M,
   input  logic [N_W-1:0]    N,
   input  logic              pd_lag,
   output logic [CODE_W-1:0] dly_code,
   output logic [SEL_W-1:0]  Sel,
   output logic              locked,
   output logic              lock_err
);

`ifdef FMDLL_PD_FILTER_EN
   localparam int WAIT = SETTLE + 2;
`else
   localparam int WAIT = SETTLE;
`endif
   localparam int SW = $clog2(WAIT + 1);
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam int DW = $clog2(LOSS_CNT + 1);
   localparam int PW = (CODE_W > 1) ? $clog2(CODE_W) : 1;

   localparam logic [CODE_W-1:0] ONE  = CODE_W'(1);
   localparam logic [CODE_W-1:0] MID  = ONE << (CODE_W - 1);
   localparam logic [CODE_W-1:0] MAXC = '1;
   localparam logic [PW-1:0]     MSB  = PW'(CODE_W - 1);
   localparam logic [SEL_W-1:0]  TOPB = SEL_W'(NUM_BANDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SAR,
      S_BAND,
      S_TRACK,
      S_FAIL
   } state_t;

   state_t            state_q, state_d;
   state_t            ret_q, ret_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic [PW-1:0]     bit_q, bit_d;
   logic [SW-1:0]     wcnt_q, wcnt_d;
   logic [LW-1:0]     lcnt_q, lcnt_d;
   logic [DW-1:0]     dcnt_q, dcnt_d;
   logic              dir_q, dir_d;
   logic              dvld_q, dvld_d;
   logic              lpd_q, lpd_d;
   logic [M_W-1:0]    m_q, m_d;
   logic [N_W-1:0]    n_q, n_d;

   logic              pd_dec;
   logic              mn_chg;
   logic              lose;
   logic [CODE_W-1:0] mask;

`ifdef FMDLL_PD_FILTER_EN
   logic [2:0] flt_q;

   // Stale samples from the previous code must not vote on the new one.
   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n) begin
         flt_q <= '0;
      end else if (code_d != code_q) begin
         flt_q <= '0;
      end else begin
         flt_q <= {flt_q[1:0], pd_lag};
      end
   end

   assign pd_dec = (flt_q[0] & flt_q[1]) |
                   (flt_q[0] & flt_q[2]) |
                   (flt_q[1] & flt_q[2]);
`else
   assign pd_dec = pd_lag;
`endif

   assign mn_chg = (M != m_q) || (N != n_q);

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      code_d   = code_q;
      sel_d    = sel_q;
      locked_d = locked_q;
      err_d    = err_q;
      bit_d    = bit_q;
      wcnt_d   = wcnt_q;
      lcnt_d   = lcnt_q;
      dcnt_d   = dcnt_q;
      dir_d    = dir_q;
      dvld_d   = dvld_q;
      lpd_d    = lpd_q;
      m_d      = m_q;
      n_d      = n_q;
      lose     = 1'b0;
      mask     = ONE << bit_q;

      unique case (state_q)
         S_IDLE: begin
            code_d   = MID;
            bit_d    = MSB;
            m_d      = M;
            n_d      = N;
            wcnt_d   = '0;
            lcnt_d   = '0;
            dcnt_d   = '0;
            dvld_d   = 1'b0;
            locked_d = 1'b0;
            err_d    = 1'b0;
            ret_d    = S_SAR;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (wcnt_q == SW'(WAIT - 1)) begin
               wcnt_d  = '0;
               state_d = ret_q;
            end else begin
               wcnt_d = wcnt_q + SW'(1);
            end
         end
         S_SAR: begin
            code_d = pd_dec ? (code_q | mask) : (code_q & ~mask);
            lpd_d  = pd_dec;
            if (bit_q == '0) begin
               state_d = S_BAND;
            end else begin
               code_d  = code_d | (mask >> 1);
               bit_d   = bit_q - PW'(1);
               wcnt_d  = '0;
               ret_d   = S_SAR;
               state_d = S_WAIT;
            end
         end
         S_BAND: begin
            // An all-ones or all-zeros code implies every decision went
            // the same way, so the last SAR sample is the band verdict.
            if (code_q == MAXC && lpd_q) begin
               if (sel_q == TOPB) begin
                  err_d   = 1'b1;
                  state_d = S_FAIL;
               end else begin
                  sel_d   = sel_q + SEL_W'(1);
                  code_d  = MID;
                  bit_d   = MSB;
                  wcnt_d  = '0;
                  ret_d   = S_SAR;
                  state_d = S_WAIT;
               end
            end else if (code_q == '0 && !lpd_q) begin
               if (sel_q == '0) begin
                  err_d   = 1'b1;
                  state_d = S_FAIL;
               end else begin
                  sel_d   = sel_q - SEL_W'(1);
                  code_d  = MID;
                  bit_d   = MSB;
                  wcnt_d  = '0;
                  ret_d   = S_SAR;
                  state_d = S_WAIT;
               end
            end else begin
               dvld_d = 1'b0;
               lcnt_d = '0;
               dcnt_d = '0;
`ifdef FMDLL_PD_FILTER_EN
               wcnt_d  = '0;
               ret_d   = S_TRACK;
               state_d = S_WAIT;
`else
               state_d = S_TRACK;
`endif
            end
         end
         S_TRACK: begin
            if ((code_q == MAXC && pd_dec) ||
                (code_q == '0 && !pd_dec)) begin
               lose = 1'b1;
            end else begin
               code_d = pd_dec ? code_q + ONE : code_q - ONE;
               dir_d  = pd_dec;
               dvld_d = 1'b1;
               if (dvld_q && (pd_dec != dir_q)) begin
                  dcnt_d = '0;
                  if (lcnt_q != LW'(LOCK_CNT)) begin
                     lcnt_d = lcnt_q + LW'(1);
                  end
                  if (lcnt_d == LW'(LOCK_CNT)) begin
                     locked_d = 1'b1;
                  end
               end else if (dvld_q) begin
                  lcnt_d = '0;
                  dcnt_d = dcnt_q + DW'(1);
               end
               if (dcnt_d == DW'(LOSS_CNT)) begin
                  lose = 1'b1;
               end else begin
                  wcnt_d  = '0;
                  ret_d   = S_TRACK;
                  state_d = S_WAIT;
               end
            end
         end
         S_FAIL: begin
            err_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (lose) begin
         locked_d = 1'b0;
         code_d   = MID;
         bit_d    = MSB;
         state_d  = S_IDLE;
      end

      // A ratio change overrides everything, including a band step.
      if (state_q != S_IDLE && mn_chg) begin
         locked_d = 1'b0;
         err_d    = 1'b0;
         code_d   = MID;
         bit_d    = MSB;
         sel_d    = sel_q;
         wcnt_d   = '0;
         state_d  = S_IDLE;
      end
   end

   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ret_q    <= S_SAR;
         code_q   <= MID;
         sel_q    <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         bit_q    <= MSB;
         wcnt_q   <= '0;
         lcnt_q   <= '0;
         dcnt_q   <= '0;
         dir_q    <= 1'b0;
         dvld_q   <= 1'b0;
         lpd_q    <= 1'b0;
         m_q      <= '0;
         n_q      <= '0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         code_q   <= code_d;
         sel_q    <= sel_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         bit_q    <= bit_d;
         wcnt_q   <= wcnt_d;
         lcnt_q   <= lcnt_d;
         dcnt_q   <= dcnt_d;
         dir_q    <= dir_d;
         dvld_q   <= dvld_d;
         lpd_q    <= lpd_d;
         m_q      <= m_d;
         n_q      <= n_d;
      end
   end

   assign dly_code = code_q;
   assign Sel      = sel_q;
   assign locked   = locked_q;
   assign lock_err = err_q;

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// tb_fmdll_lock_ctrl: ideal phase-detector plant plus timing formulas
// derived from the search/track rules; honours FMDLL_PD_FILTER_EN.
module tb_fmdll_lock_ctrl;

   localparam int CODE_W   = 6;
   localparam int SETTLE   = 4;
   localparam int LOCK_CNT = 8;
   localparam int LOSS_CNT = 4;
   localparam int MID      = 32;
   localparam int MAXC     = 63;
`ifdef FMDLL_PD_FILTER_EN
   localparam int SPW   = SETTLE + 3;
   localparam int FIRST = CODE_W * SPW + 2 + SPW;
`else
   localparam int SPW   = SETTLE + 1;
   localparam int FIRST = CODE_W * SPW + 2 + 1;
`endif
   localparam int LAT   = CODE_W * SPW + 2;
   localparam int LOCKE = FIRST + LOCK_CNT * SPW;

   logic       clk_ext = 1'b0;
   logic       rst_n   = 1'b0;
   logic [1:0] M       = 2'd3;
   logic [3:0] N       = 4'd10;
   logic       pd_lag;
   logic [5:0] dly_code;
   logic [1:0] Sel;
   logic       locked;
   logic       lock_err;

   int target = 37;
   logic glitch = 1'b0;
   int n_chk = 0;
   int n_pass = 0;

   // Ideal detector: delay too short while code is at or below the target.
   assign pd_lag = ((int'(dly_code) <= target) ? 1'b1 : 1'b0) ^ glitch;

   always #5 clk_ext = ~clk_ext;

   fmdll_lock_ctrl dut (
      .clk_ext  (clk_ext),
      .rst_n    (rst_n),
      .M        (M),
      .N        (N),
      .pd_lag   (pd_lag),
      .dly_code (dly_code),
      .Sel      (Sel),
      .locked   (locked),
      .lock_err (lock_err)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk_ext);
      #1;
   endtask

   task automatic do_reset(input int tgt);
      rst_n  = 1'b0;
      M      = 2'd3;
      N      = 4'd10;
      glitch = 1'b0;
      target = tgt;
      wait_edges(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_edges(2);
      n_chk++;
      if (dly_code !== 6'(MID))
         $display("FAIL reset_code: got %0d want %0d", dly_code, MID);
      else n_pass++;
      n_chk++;
      if (Sel !== 2'd0) $display("FAIL reset_sel: got %0d want 0", Sel);
      else n_pass++;
      n_chk++;
      if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked);
      else n_pass++;
      n_chk++;
      if (lock_err !== 1'b0) $display("FAIL reset_err: got %b want 0", lock_err);
      else n_pass++;
   endtask

   task automatic test_coarse_lock(input int tgt);
      do_reset(tgt);
      wait_edges(LAT);
      n_chk++;
      if (dly_code !== 6'(tgt))
         $display("FAIL coarse_code: got %0d want %0d", dly_code, tgt);
      else n_pass++;
      n_chk++;
      if (Sel !== 2'd0 || locked !== 1'b0)
         $display("FAIL coarse_state: sel %0d locked %b want 0 0", Sel, locked);
      else n_pass++;
      wait_edges(LOCKE - LAT - 1);
      n_chk++;
      if (locked !== 1'b0) $display("FAIL early_lock: got %b want 0", locked);
      else n_pass++;
      wait_edges(1);
      n_chk++;
      if (locked !== 1'b1) $display("FAIL lock_assert: got %b want 1", locked);
      else n_pass++;
      n_chk++;
      if (dly_code !== 6'(tgt + 1))
         $display("FAIL lock_code: got %0d want %0d", dly_code, tgt + 1);
      else n_pass++;
   endtask

   task automatic test_random_lock();
      for (int i = 0; i < 3; i++) begin
         test_coarse_lock(int'($urandom_range(1, 61)));
      end
   endtask

   task automatic test_band_fail();
      do_reset(1000);
      wait_edges(LAT);
      n_chk++;
      if (Sel !== 2'd1 || dly_code !== 6'(MID))
         $display("FAIL band_step0: sel %0d code %0d want 1 %0d", Sel, dly_code, MID);
      else n_pass++;
      for (int b = 2; b <= 3; b++) begin
         wait_edges(CODE_W * SPW + 1);
         n_chk++;
         if (Sel !== 2'(b)) $display("FAIL band_step: got %0d want %0d", Sel, b);
         else n_pass++;
      end
      wait_edges(CODE_W * SPW);
      n_chk++;
      if (lock_err !== 1'b0 || dly_code !== 6'(MAXC))
         $display("FAIL pre_fail: err %b code %0d want 0 %0d", lock_err, dly_code, MAXC);
      else n_pass++;
      wait_edges(1);
      n_chk++;
      if (lock_err !== 1'b1) $display("FAIL fail_err: got %b want 1", lock_err);
      else n_pass++;
      wait_edges(20);
      n_chk++;
      if (Sel !== 2'd3 || dly_code !== 6'(MAXC) || lock_err !== 1'b1 || locked !== 1'b0)
         $display("FAIL fail_frozen: sel %0d code %0d err %b lk %b want 3 63 1 0",
                  Sel, dly_code, lock_err, locked);
      else n_pass++;
      M = 2'd1;
      wait_edges(1);
      n_chk++;
      if (lock_err !== 1'b0 || Sel !== 2'd3 || dly_code !== 6'(MID))
         $display("FAIL fail_exit: err %b sel %0d code %0d want 0 3 %0d",
                  lock_err, Sel, dly_code, MID);
      else n_pass++;
   endtask

   task automatic test_mn_change();
      int t2;
      do_reset(20);
      wait_edges(LOCKE);
      n_chk++;
      if (locked !== 1'b1 || dly_code !== 6'd21)
         $display("FAIL mn_prelock: lk %b code %0d want 1 21", locked, dly_code);
      else n_pass++;
      N = 4'd8;
      wait_edges(1);
      n_chk++;
      if (locked !== 1'b0 || dly_code !== 6'(MID))
         $display("FAIL mn_abort: lk %b code %0d want 0 %0d", locked, dly_code, MID);
      else n_pass++;
      t2 = int'($urandom_range(1, 61));
      target = t2;
      wait_edges(LAT);
      n_chk++;
      if (dly_code !== 6'(t2) || Sel !== 2'd0)
         $display("FAIL mn_relock: code %0d sel %0d want %0d 0", dly_code, Sel, t2);
      else n_pass++;
   endtask

   task automatic test_track_loss();
      int t;
      t = int'($urandom_range(1, 50));
      do_reset(t);
      wait_edges(LOCKE);
      n_chk++;
      if (locked !== 1'b1) $display("FAIL loss_prelock: got %b want 1", locked);
      else n_pass++;
      for (int i = 1; i <= LOSS_CNT; i++) begin
         target = target + 1;
         wait_edges(SPW);
         n_chk++;
         if (i < LOSS_CNT) begin
            if (locked !== 1'b1)
               $display("FAIL loss_hold%0d: got %b want 1", i, locked);
            else n_pass++;
         end else begin
            if (locked !== 1'b0 || dly_code !== 6'(MID))
               $display("FAIL loss_drop: lk %b code %0d want 0 %0d", locked, dly_code, MID);
            else n_pass++;
         end
      end
   endtask

   task automatic test_async_reset();
      int t;
      do_reset(1000);
      wait_edges(LAT + 10);
      n_chk++;
      if (Sel !== 2'd1 || dly_code === 6'(MID))
         $display("FAIL ares_pre: sel %0d code %0d want 1 and not %0d", Sel, dly_code, MID);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (dly_code !== 6'(MID) || Sel !== 2'd0 || locked !== 1'b0 || lock_err !== 1'b0)
         $display("FAIL ares_now: code %0d sel %0d lk %b err %b want %0d 0 0 0",
                  dly_code, Sel, locked, lock_err, MID);
      else n_pass++;
      t = int'($urandom_range(1, 61));
      target = t;
      wait_edges(2);
      rst_n = 1'b1;
      wait_edges(LAT);
      n_chk++;
      if (dly_code !== 6'(t) || Sel !== 2'd0)
         $display("FAIL ares_restart: code %0d sel %0d want %0d 0", dly_code, Sel, t);
      else n_pass++;
   endtask

`ifdef FMDLL_PD_FILTER_EN
   task automatic test_glitch();
      int t, k, g, x;
      for (int r = 0; r < 3; r++) begin
         t = int'($urandom_range(1, 61));
         k = int'($urandom_range(0, CODE_W - 1));
         g = int'($urandom_range(1, 3));
         x = 1 + (k + 1) * SPW - g;
         do_reset(t);
         wait_edges(x - 1);
         glitch = 1'b1;
         wait_edges(1);
         glitch = 1'b0;
         wait_edges(LAT - x);
         n_chk++;
         if (dly_code !== 6'(t))
            $display("FAIL glitch_code: got %0d want %0d", dly_code, t);
         else n_pass++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_coarse_lock(37);
      test_random_lock();
      test_band_fail();
      test_mn_change();
      test_track_loss();
      test_async_reset();
`ifdef FMDLL_PD_FILTER_EN
      test_glitch();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fmdll_lock_ctrl.md
Name: fmdll_lock_ctrl

Overview:
Parametrised digital lock controller for the next-generation frequency-multiplying DLL. It runs on the reference clock clk_ext and reads a bang-bang phase-detector bit from the delay line. It drives a band select (Sel) and a fine delay code. It performs a coarse SAR search, then switches to linear tracking, and flags lock, loss of lock and search failure. M/N ratio changes force an automatic relock.

Parameters:
CODE_W, 6, fine delay code width (code range 0..2^CODE_W-1)
SEL_W, 2, band select width
NUM_BANDS, 4, legal bands 0..NUM_BANDS-1 (NUM_BANDS <= 2^SEL_W)
M_W, 2, width of M ratio input
N_W, 4, width of N ratio input
SETTLE, 4, clk_ext cycles to wait after any code/Sel change before sampling pd_lag (>=1)
LOCK_CNT, 8, consecutive in-window track decisions required to assert locked
LOSS_CNT, 4, consecutive same-direction track steps that declare loss of lock

Ports:
clk_ext  input  1  reference clock; sole clock domain
rst_n  input  1  asynchronous active-low reset
M  input  M_W  multiplication numerator; any change restarts the search
N  input  N_W  multiplication denominator; any change restarts the search
pd_lag  input  1  phase-detector result, synchronous to clk_ext; 1 = delay too short (add delay), 0 = too long
dly_code  output  CODE_W  fine delay code to the delay line
Sel  output  SEL_W  coarse band select
locked  output  1  lock indicator
lock_err  output  1  search failed: no band fits; sticky until restart

Behaviour:
- Reset (async assert, sync release): state=IDLE, dly_code=2^(CODE_W-1), Sel=0, locked=0, lock_err=0, all counters=0.
- M/N are registered once. A difference between input and register in any non-IDLE state returns the block to IDLE next cycle (locked=0, lock_err=0, Sel kept). This takes priority over every other transition.
- IDLE: one cycle. Load dly_code=mid, clear bit pointer to MSB, go to SETTLE_WAIT.
- SETTLE_WAIT: count SETTLE cycles. Then go to the return state (SAR or TRACK).
- SAR: per bit from MSB to LSB, the current bit is trial-set. On the sample, keep the bit if pd_lag=1, else clear it. Set the next-lower bit. Go to SETTLE_WAIT. After the LSB decision go to BAND_CHK. Coarse lock latency = CODE_W*(SETTLE+1)+2 cycles.
- BAND_CHK:
  - code==all-ones with pd_lag=1: Sel+1 and restart SAR.
  - code==0 with pd_lag=0: Sel-1 and restart SAR.
  - Stepping past band 0 or NUM_BANDS-1: go to FAIL.
  - Otherwise go to TRACK.
- TRACK: each decision steps dly_code ±1 per pd_lag, saturating at 0 and at max, then SETTLE_WAIT.
  - A step opposite to the previous one is in-window: increments lock_cnt and clears dir_cnt.
  - A same-direction step increments dir_cnt and clears lock_cnt.
  - locked=1 when lock_cnt reaches LOCK_CNT; lock_cnt saturates.
- Loss of lock: dir_cnt==LOSS_CNT, or a saturated code with pd pushing outward. Action: locked=0, go to IDLE (Sel kept).
- FAIL: lock_err=1, dly_code and Sel frozen. Exit only via reset or an M/N change.
- Outputs are registered; dly_code/Sel change only on state-machine update cycles.

Optional Feature:
FMDLL_PD_FILTER_EN
- Defined: pd_lag passes through a 3-sample majority filter. Each decision takes the majority of the last 3 samples, so the settle wait becomes SETTLE+2 cycles per decision. Filter samples are cleared on reset and on every code change.
- Undefined: the raw pd_lag value in the sample cycle is used. Timing is as stated above.

Test Plan:
1. Reset, M=3, N=10, pd_lag driven by ideal model with target code 37 in band 0 -> dly_code=37 after 6*(SETTLE+1)+2 cycles, Sel=0, locked=1 after 8 alternating track steps.
2. Target code beyond max in band 0 (pd_lag stuck 1) -> SAR ends at 63, Sel steps 0->1->2->3, then FAIL with lock_err=1 and Sel=3 frozen.
3. Locked at code 20, then N changes 10->8 -> next cycle locked=0, state IDLE, dly_code=32, new search begins.
4. Locked, then model target drifts +1 per decision for 4 decisions -> locked deasserts on the 4th same-direction step and relock starts.
5. rst_n asserted mid-SAR (asynchronously, between clk_ext edges) -> outputs immediately take reset values; after release the search restarts from code 32, Sel=0.
6. Build with FMDLL_PD_FILTER_EN and a single-cycle pd_lag glitch inside the sample window -> decision unchanged, same final code as the glitch-free run.
